// File: rtl/pipe_stage_register.sv
// pipe_stage_register
//   Inter-stage pipeline register for the Y86-64 pipeline (F->D, D->E, ...)
//   carrying LANES parallel instruction slots. Global stall holds every lane;
//   a per-lane bubble mask squashes selected lanes to a NOP. Priority per
//   edge: stall > bubble > load.
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   in_icode/ifun/ra/rb   4 bits per lane, lane i at [4i+3:4i]
//   in_valc/in_valp       VAL_W bits per lane
//   in_status             2 bits per lane
//   stall                 hold all lanes (bubble ignored while high)
//   bubble                per-lane squash request
//   out_*                 registered copies of the lane fields
//   out_valid             per lane: 1 = real (non-bubble) instruction
//   stall_cnt             consecutive stall cycles, saturating
//   ctl_conflict          sticky: stall and any bubble seen in same cycle
//   perf_bubbles          squashed-lane count
//
// Configuration
//   PIPE_REG_PERF_EN      defined: perf_bubbles accumulates popcount(bubble)
//                         on every non-stall cycle (32-bit, wrapping).
//                         undefined: perf_bubbles is constant 0.

module pipe_stage_register #(
   parameter int unsigned LANES        = 1,
   parameter int unsigned VAL_W        = 64,
   parameter logic [3:0]  BUBBLE_ICODE = 4'h1,
   parameter logic [3:0]  RNONE        = 4'hF,
   parameter logic [1:0]  STAT_AOK     = 2'd0,
   parameter int unsigned CNT_W        = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [4*LANES-1:0]     in_icode,
   input  logic [4*LANES-1:0]     in_ifun,
   input  logic [4*LANES-1:0]     in_ra,
   input  logic [4*LANES-1:0]     in_rb,
   input  logic [VAL_W*LANES-1:0] in_valc,
   input  logic [VAL_W*LANES-1:0] in_valp,
   input  logic [2*LANES-1:0]     in_status,
   input  logic                   stall,
   input  logic [LANES-1:0]       bubble,
   output logic [4*LANES-1:0]     out_icode,
   output logic [4*LANES-1:0]     out_ifun,
   output logic [4*LANES-1:0]     out_ra,
   output logic [4*LANES-1:0]     out_rb,
   output logic [VAL_W*LANES-1:0] out_valc,
   output logic [VAL_W*LANES-1:0] out_valp,
   output logic [2*LANES-1:0]     out_status,
   output logic [LANES-1:0]       out_valid,
   output logic [CNT_W-1:0]       stall_cnt,
   output logic                   ctl_conflict,
   output logic [31:0]            perf_bubbles
);

   logic [4*LANES-1:0]     r_icode;
   logic [4*LANES-1:0]     r_ifun;
   logic [4*LANES-1:0]     r_ra;
   logic [4*LANES-1:0]     r_rb;
   logic [VAL_W*LANES-1:0] r_valc;
   logic [VAL_W*LANES-1:0] r_valp;
   logic [2*LANES-1:0]     r_status;
   logic [LANES-1:0]       r_valid;
   logic [CNT_W-1:0]       r_stall_cnt;
   logic                   r_conflict;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_icode  <= {LANES{BUBBLE_ICODE}};
         r_ifun   <= '0;
         r_ra     <= {LANES{RNONE}};
         r_rb     <= {LANES{RNONE}};
         r_valc   <= '0;
         r_valp   <= '0;
         r_status <= {LANES{STAT_AOK}};
         r_valid  <= '0;
      end else if (!stall) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (bubble[i]) begin
               r_icode[4*i +: 4]        <= BUBBLE_ICODE;
               r_ifun[4*i +: 4]         <= '0;
               r_ra[4*i +: 4]           <= RNONE;
               r_rb[4*i +: 4]           <= RNONE;
               r_valc[VAL_W*i +: VAL_W] <= '0;
               r_valp[VAL_W*i +: VAL_W] <= '0;
               r_status[2*i +: 2]       <= STAT_AOK;
               r_valid[i]               <= 1'b0;
            end else begin
               r_icode[4*i +: 4]        <= in_icode[4*i +: 4];
               r_ifun[4*i +: 4]         <= in_ifun[4*i +: 4];
               r_ra[4*i +: 4]           <= in_ra[4*i +: 4];
               r_rb[4*i +: 4]           <= in_rb[4*i +: 4];
               r_valc[VAL_W*i +: VAL_W] <= in_valc[VAL_W*i +: VAL_W];
               r_valp[VAL_W*i +: VAL_W] <= in_valp[VAL_W*i +: VAL_W];
               r_status[2*i +: 2]       <= in_status[2*i +: 2];
               // A NOP coming down the pipe is not counted as a real instruction.
               r_valid[i]               <= (in_icode[4*i +: 4] != BUBBLE_ICODE);
            end
         end
      end
   end

   // Saturating consecutive-stall counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (stall) begin
         if (r_stall_cnt != '1) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end else begin
         r_stall_cnt <= '0;
      end
   end

   // Sticky flag: hazard unit asked for both hold and squash in one cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_conflict <= 1'b0;
      end else if (stall && (|bubble)) begin
         r_conflict <= 1'b1;
      end
   end

`ifdef PIPE_REG_PERF_EN
   logic [31:0] r_perf;
   logic [31:0] w_pop;

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         w_pop = w_pop + 32'(bubble[i]);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_perf <= '0;
      end else if (!stall) begin
         r_perf <= r_perf + w_pop;
      end
   end

   assign perf_bubbles = r_perf;
`else
   assign perf_bubbles = '0;
`endif

   assign out_icode    = r_icode;
   assign out_ifun     = r_ifun;
   assign out_ra       = r_ra;
   assign out_rb       = r_rb;
   assign out_valc     = r_valc;
   assign out_valp     = r_valp;
   assign out_status   = r_status;
   assign out_valid    = r_valid;
   assign stall_cnt    = r_stall_cnt;
   assign ctl_conflict = r_conflict;

endmodule

// File: tb/tb_pipe_stage_register.sv
// tb_pipe_stage_register
//   Self-checking bench for pipe_stage_register with LANES=2, VAL_W=64,
//   CNT_W=4. A behavioural model computes the expected register contents
//   when stimulus is driven and queues them; they are popped and compared
//   one clock later. Honours PIPE_REG_PERF_EN for the perf counter.

module tb_pipe_stage_register;

   localparam int unsigned L = 2;
   localparam int unsigned W = 64;
   localparam int unsigned C = 4;

   logic           clock = 1'b0;
   logic           reset;
   logic [4*L-1:0] in_icode, in_ifun, in_ra, in_rb;
   logic [W*L-1:0] in_valc, in_valp;
   logic [2*L-1:0] in_status;
   logic           stall;
   logic [L-1:0]   bubble;
   logic [4*L-1:0] out_icode, out_ifun, out_ra, out_rb;
   logic [W*L-1:0] out_valc, out_valp;
   logic [2*L-1:0] out_status;
   logic [L-1:0]   out_valid;
   logic [C-1:0]   stall_cnt;
   logic           ctl_conflict;
   logic [31:0]    perf_bubbles;

   pipe_stage_register #(
      .LANES(L), .VAL_W(W), .BUBBLE_ICODE(4'h1), .RNONE(4'hF),
      .STAT_AOK(2'd0), .CNT_W(C)
   ) dut (
      .clock(clock), .reset(reset),
      .in_icode(in_icode), .in_ifun(in_ifun), .in_ra(in_ra), .in_rb(in_rb),
      .in_valc(in_valc), .in_valp(in_valp), .in_status(in_status),
      .stall(stall), .bubble(bubble),
      .out_icode(out_icode), .out_ifun(out_ifun), .out_ra(out_ra), .out_rb(out_rb),
      .out_valc(out_valc), .out_valp(out_valp), .out_status(out_status),
      .out_valid(out_valid), .stall_cnt(stall_cnt), .ctl_conflict(ctl_conflict),
      .perf_bubbles(perf_bubbles)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4*L-1:0] icode, ifun, ra, rb;
      logic [W*L-1:0] valc, valp;
      logic [2*L-1:0] status;
      logic [L-1:0]   valid;
      logic [C-1:0]   cnt;
      logic           conflict;
      logic [31:0]    perf;
   } exp_t;

   typedef struct {
      string          name;
      logic           st;
      logic [L-1:0]   bb;
      logic [4*L-1:0] ic;
      logic [L-1:0]   exp_valid;
      logic [C-1:0]   exp_cnt;
   } vec_t;

   exp_t m;
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic model_reset();
      m.icode = 8'h11; m.ifun = '0; m.ra = 8'hFF; m.rb = 8'hFF;
      m.valc = '0; m.valp = '0; m.status = '0; m.valid = '0;
      m.cnt = '0; m.conflict = 1'b0; m.perf = '0;
   endtask

   task automatic compare_state(input string tag, input exp_t e);
      chk({tag, ".icode"},    out_icode,    e.icode);
      chk({tag, ".ifun"},     out_ifun,     e.ifun);
      chk({tag, ".ra"},       out_ra,       e.ra);
      chk({tag, ".rb"},       out_rb,       e.rb);
      chk({tag, ".valc"},     out_valc,     e.valc);
      chk({tag, ".valp"},     out_valp,     e.valp);
      chk({tag, ".status"},   out_status,   e.status);
      chk({tag, ".valid"},    out_valid,    e.valid);
      chk({tag, ".cnt"},      stall_cnt,    e.cnt);
      chk({tag, ".conflict"}, ctl_conflict, e.conflict);
`ifdef PIPE_REG_PERF_EN
      chk({tag, ".perf"},     perf_bubbles, e.perf);
`else
      chk({tag, ".perf"},     perf_bubbles, 128'd0);
`endif
   endtask

   // Drive one cycle, update model, push expected, wait edge, pop and compare.
   task automatic cycle_full(input string tag, input logic st, input logic [L-1:0] bb,
                             input logic [4*L-1:0] ic, input logic [4*L-1:0] fn,
                             input logic [4*L-1:0] a, input logic [4*L-1:0] b,
                             input logic [W*L-1:0] vc, input logic [W*L-1:0] vp,
                             input logic [2*L-1:0] ss);
      exp_t e;
      stall = st; bubble = bb; in_icode = ic; in_ifun = fn; in_ra = a; in_rb = b;
      in_valc = vc; in_valp = vp; in_status = ss;
      if (!st) begin
         for (int i = 0; i < int'(L); i++) begin
            if (bb[i]) begin
               m.icode[4*i +: 4] = 4'h1; m.ifun[4*i +: 4] = 4'h0;
               m.ra[4*i +: 4] = 4'hF;    m.rb[4*i +: 4] = 4'hF;
               m.valc[W*i +: W] = '0;    m.valp[W*i +: W] = '0;
               m.status[2*i +: 2] = 2'd0; m.valid[i] = 1'b0;
               m.perf = m.perf + 32'd1;
            end else begin
               m.icode[4*i +: 4] = ic[4*i +: 4]; m.ifun[4*i +: 4] = fn[4*i +: 4];
               m.ra[4*i +: 4] = a[4*i +: 4];     m.rb[4*i +: 4] = b[4*i +: 4];
               m.valc[W*i +: W] = vc[W*i +: W];  m.valp[W*i +: W] = vp[W*i +: W];
               m.status[2*i +: 2] = ss[2*i +: 2];
               m.valid[i] = (ic[4*i +: 4] != 4'h1);
            end
         end
         m.cnt = '0;
      end else begin
         if (m.cnt != 4'd15) m.cnt = m.cnt + 4'd1;
         if (bb != '0) m.conflict = 1'b1;
      end
      sb.push_back(m);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         n_checks++; n_fail++;
         $display("FAIL %s scoreboard empty actual=0 required=1", tag);
      end else begin
         e = sb.pop_front();
         compare_state(tag, e);
      end
   endtask

   task automatic cycle(input string tag, input logic st, input logic [L-1:0] bb,
                        input logic [4*L-1:0] ic);
      cycle_full(tag, st, bb, ic, 8'($urandom), 8'($urandom), 8'($urandom),
                 {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 4'($urandom));
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      model_reset();
      compare_state(tag, m);
      @(negedge clock);
      reset = 1'b0;
   endtask

   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4*L-1:0] held;
      vecs[0] = '{"v0_load_both",  1'b0, 2'b00, 8'h26, 2'b11, 4'd0};
      vecs[1] = '{"v1_bub_lane1",  1'b0, 2'b10, 8'h37, 2'b01, 4'd0};
      vecs[2] = '{"v2_bub_lane0",  1'b0, 2'b01, 8'h5A, 2'b10, 4'd0};
      vecs[3] = '{"v3_nop_lane1",  1'b0, 2'b00, 8'h16, 2'b01, 4'd0};
      vecs[4] = '{"v4_bub_both",   1'b0, 2'b11, 8'h77, 2'b00, 4'd0};
      vecs[5] = '{"v5_nop_both",   1'b0, 2'b00, 8'h11, 2'b00, 4'd0};
      vecs[6] = '{"v6_load_b0",    1'b0, 2'b00, 8'hB0, 2'b11, 4'd0};
      vecs[7] = '{"v7_stall1",     1'b1, 2'b00, 8'h22, 2'b11, 4'd1};
      vecs[8] = '{"v8_stall2",     1'b1, 2'b00, 8'h33, 2'b11, 4'd2};
      vecs[9] = '{"v9_resume",     1'b0, 2'b00, 8'h1C, 2'b01, 4'd0};

      reset = 1'b1; stall = 1'b0; bubble = '0;
      in_icode = '0; in_ifun = '0; in_ra = '0; in_rb = '0;
      in_valc = '0; in_valp = '0; in_status = '0;
      model_reset();
      @(negedge clock); @(negedge clock);
      compare_state("reset_init", m);
      reset = 1'b0;

      // Single load with known fields.
      cycle_full("load", 1'b0, 2'b00, 8'h96, 8'h10, 8'h42, 8'h53,
                 {64'h20, 64'h10}, {64'h204, 64'h102}, 4'b0100);
      chk("load.icode0", out_icode[3:0], 4'h6);
      chk("load.ra0",    out_ra[3:0],    4'h2);
      chk("load.rb0",    out_rb[3:0],    4'h3);
      chk("load.valc0",  out_valc[63:0], 64'h10);
      chk("load.valp0",  out_valp[63:0], 64'h102);
      chk("load.valid0", out_valid[0],   1'b1);

      for (int k = 0; k < 10; k++) begin
         cycle(vecs[k].name, vecs[k].st, vecs[k].bb, vecs[k].ic);
         chk({vecs[k].name, ".tbl_valid"}, out_valid, vecs[k].exp_valid);
         chk({vecs[k].name, ".tbl_cnt"},   stall_cnt, vecs[k].exp_cnt);
      end

      // Long stall: frozen outputs, saturating counter.
      held = out_icode;
      for (int k = 1; k <= 20; k++) begin
         cycle("stall20", 1'b1, 2'b00, 8'($urandom));
         chk("stall20.cnt_sat", stall_cnt, (k < 15) ? k : 15);
         chk("stall20.frozen",  out_icode, held);
      end
      cycle("stall_release", 1'b0, 2'b00, 8'h9A);
      chk("stall_release.cnt",   stall_cnt, 4'd0);
      chk("stall_release.icode", out_icode, 8'h9A);

      // Stall and bubble together: hold wins, conflict sticks.
      cycle("pre_conflict", 1'b0, 2'b00, 8'h66);
      cycle("conflict", 1'b1, 2'b01, 8'h22);
      chk("conflict.lane0_held",  out_icode[3:0], 4'h6);
      chk("conflict.valid0_held", out_valid[0],   1'b1);
      chk("conflict.flag",        ctl_conflict,   1'b1);
      cycle("post_conflict1", 1'b0, 2'b00, 8'h33);
      cycle("post_conflict2", 1'b0, 2'b11, 8'h44);
      chk("post_conflict.sticky", ctl_conflict, 1'b1);

      // Perf counter: 3 squash cycles of both lanes, then a stalled one.
      @(negedge clock);
      do_reset("reset_perf");
      cycle("perf1", 1'b0, 2'b11, 8'h66);
      cycle("perf2", 1'b0, 2'b11, 8'h66);
      cycle("perf3", 1'b0, 2'b11, 8'h66);
      cycle("perf_stall", 1'b1, 2'b11, 8'h66);
`ifdef PIPE_REG_PERF_EN
      chk("perf.total", perf_bubbles, 32'd6);
`else
      chk("perf.total", perf_bubbles, 32'd0);
`endif

      // Reset asserted mid-stall, between clock edges.
      cycle("pre_rst_load", 1'b0, 2'b00, 8'h66);
      cycle("pre_rst_stall", 1'b1, 2'b00, 8'h77);
      do_reset("reset_midrun");
      chk("reset_midrun.valid", out_valid, 2'b00);
      cycle("after_reset", 1'b0, 2'b01, 8'h66);
      chk("after_reset.valid", out_valid, 2'b10);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
